// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, one-hot register selects and
// instruction field positions used by the decode stage.
package cpu_pkg;

   localparam int INSTR_W = 16;

   localparam logic [2:0] MOV  = 3'b110;
   localparam logic [2:0] ALU  = 3'b101;
   localparam logic [2:0] LDR  = 3'b011;
   localparam logic [2:0] STR  = 3'b100;
   localparam logic [2:0] HALT = 3'b111;

   localparam logic [2:0] NSEL_RN = 3'b001;
   localparam logic [2:0] NSEL_RD = 3'b010;
   localparam logic [2:0] NSEL_RM = 3'b100;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int OP_HI  = 12;
   localparam int OP_LO  = 11;
   localparam int RN_HI  = 10;
   localparam int RN_LO  = 8;
   localparam int RD_HI  = 7;
   localparam int RD_LO  = 5;
   localparam int SH_HI  = 4;
   localparam int SH_LO  = 3;
   localparam int RM_HI  = 2;
   localparam int RM_LO  = 0;
   localparam int IMM5_W = 5;
   localparam int IMM8_W = 8;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v == NSEL_RN) || (v == NSEL_RD) || (v == NSEL_RM);
   endfunction

endpackage

// File: rtl/sign_extend.sv
// Replicates the top bit of an IN_W-bit field up to OUT_W bits.
module sign_extend #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  in_i,
   output logic [OUT_W-1:0] ext_o
);

   assign ext_o = {{(OUT_W-IN_W){in_i[IN_W-1]}}, in_i};

endmodule

// File: rtl/instr_decode_queue.sv
// Instruction queue feeding the control FSM: valid/ready FIFO whose head
// entry is decoded combinationally into fields, register numbers and immediates.
module instr_decode_queue
   import cpu_pkg::*;
#(
   parameter int         DEPTH        = 2,
   parameter int         IMM_W        = 16,
   parameter logic [7:0] ILLEGAL_MASK = 8'b0000_0111
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INSTR_W-1:0]      in_instr,
   input  logic                    flush,
   input  logic [2:0]              nsel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2:0]              opcode,
   output logic [1:0]              op,
   output logic [1:0]              shift,
   output logic [2:0]              readnum,
   output logic [2:0]              writenum,
   output logic [IMM_W-1:0]        sximm5,
   output logic [IMM_W-1:0]        sximm8,
   output logic                    illegal,
   output logic                    nsel_err,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               push, pop;
   logic [INSTR_W-1:0] head;
   logic [2:0]         reg_sel;

   assign in_ready  = (cnt_q != FULL) && !flush;
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // flush wins over pop; push is already blocked through in_ready
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = wr_q + AW'(1);
         if (pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push) mem_q[wr_q] <= in_instr;
      end
   end

   assign head   = mem_q[rd_q];
   assign opcode = head[OPC_HI:OPC_LO];
   assign op     = head[OP_HI:OP_LO];
   assign shift  = head[SH_HI:SH_LO];
   assign count  = cnt_q;

   always_comb begin
      reg_sel = '0;
      case (nsel)
         NSEL_RN: reg_sel = head[RN_HI:RN_LO];
         NSEL_RD: reg_sel = head[RD_HI:RD_LO];
         NSEL_RM: reg_sel = head[RM_HI:RM_LO];
         default: reg_sel = '0;
      endcase
   end

   assign readnum  = reg_sel;
   assign writenum = reg_sel;

   // An empty queue shows a stale head, so the error flags are qualified here
   assign nsel_err = out_valid && !is_onehot3(nsel);
   assign illegal  = out_valid && ILLEGAL_MASK[opcode];

   sign_extend #(.IN_W(IMM5_W), .OUT_W(IMM_W)) u_sx5 (
      .in_i  (head[IMM5_W-1:0]),
      .ext_o (sximm5)
   );

   sign_extend #(.IN_W(IMM8_W), .OUT_W(IMM_W)) u_sx8 (
      .in_i  (head[IMM8_W-1:0]),
      .ext_o (sximm8)
   );

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: two instances (16- and 32-bit
// immediates) share stimulus and are compared every cycle to a queue model.
module tb_instr_decode_queue;
   import cpu_pkg::*;

   localparam int         DEPTH = 2;
   localparam logic [7:0] MASK  = 8'b0000_0111;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_instr = '0;
   logic [2:0]  nsel = 3'b001;

   logic        a_in_ready, a_out_valid, a_illegal, a_nsel_err;
   logic [2:0]  a_opcode, a_readnum, a_writenum;
   logic [1:0]  a_op, a_shift, a_count;
   logic [15:0] a_sximm5, a_sximm8;

   logic        b_in_ready, b_out_valid, b_illegal, b_nsel_err;
   logic [2:0]  b_opcode, b_readnum, b_writenum;
   logic [1:0]  b_op, b_shift, b_count;
   logic [31:0] b_sximm5, b_sximm8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_decode_queue #(.DEPTH(DEPTH), .IMM_W(16), .ILLEGAL_MASK(MASK)) dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .flush(flush), .nsel(nsel), .out_valid(a_out_valid),
      .out_ready(out_ready), .opcode(a_opcode), .op(a_op), .shift(a_shift),
      .readnum(a_readnum), .writenum(a_writenum), .sximm5(a_sximm5), .sximm8(a_sximm8),
      .illegal(a_illegal), .nsel_err(a_nsel_err), .count(a_count)
   );

   instr_decode_queue #(.DEPTH(DEPTH), .IMM_W(32), .ILLEGAL_MASK(MASK)) dut32 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .flush(flush), .nsel(nsel), .out_valid(b_out_valid),
      .out_ready(out_ready), .opcode(b_opcode), .op(b_op), .shift(b_shift),
      .readnum(b_readnum), .writenum(b_writenum), .sximm5(b_sximm5), .sximm8(b_sximm8),
      .illegal(b_illegal), .nsel_err(b_nsel_err), .count(b_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a plain queue of instruction words
   logic [15:0] mq[$];
   bit          pristine = 1'b1;

   always @(posedge clk or negedge reset_n) begin
      bit do_push, do_pop;
      if (!reset_n) begin
         mq.delete();
         pristine = 1'b1;
      end else begin
         do_push = in_valid && (mq.size() != DEPTH) && !flush;
         do_pop  = (mq.size() != 0) && out_ready;
         if (flush) mq.delete();
         else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               mq.push_back(in_instr);
               pristine = 1'b0;
            end
         end
      end
   end

   task automatic check_dut(input string tag, input int imm_w,
                            input logic ov, input logic ir, input logic [31:0] cnt,
                            input logic [2:0] opc, input logic [1:0] opv, input logic [1:0] sh,
                            input logic [2:0] rn, input logic [2:0] wn,
                            input logic [31:0] s5, input logic [31:0] s8,
                            input logic ill, input logic nerr);
      logic [15:0] w;
      logic [31:0] e5, e8;
      bit          valid, onehot;
      int          wi, eopc, esel;
      valid  = (mq.size() != 0);
      onehot = (nsel == 3'd1) || (nsel == 3'd2) || (nsel == 3'd4);
      w      = valid ? mq[0] : 16'h0000;
      wi     = int'(w);
      eopc   = wi / 8192;
      chk({tag, ".out_valid"}, ov, valid);
      chk({tag, ".in_ready"}, ir, (mq.size() != DEPTH) && !flush);
      chk({tag, ".count"}, cnt, mq.size());
      chk({tag, ".illegal"}, ill, valid && MASK[eopc]);
      chk({tag, ".nsel_err"}, nerr, valid && !onehot);
      if (valid || pristine) begin
         if (nsel == 3'd1)      esel = (wi / 256) % 8;
         else if (nsel == 3'd2) esel = (wi / 32) % 8;
         else if (nsel == 3'd4) esel = wi % 8;
         else                   esel = 0;
         e5 = w[4] ? 32'(w[4:0]) - 32'd32  : 32'(w[4:0]);
         e8 = w[7] ? 32'(w[7:0]) - 32'd256 : 32'(w[7:0]);
         if (imm_w == 16) begin
            e5 = e5 & 32'h0000_FFFF;
            e8 = e8 & 32'h0000_FFFF;
         end
         chk({tag, ".opcode"}, opc, eopc);
         chk({tag, ".op"}, opv, (wi / 2048) % 4);
         chk({tag, ".shift"}, sh, (wi / 8) % 4);
         chk({tag, ".readnum"}, rn, esel);
         chk({tag, ".writenum"}, wn, esel);
         chk({tag, ".sximm5"}, s5, e5);
         chk({tag, ".sximm8"}, s8, e8);
      end
   endtask

   always @(negedge clk) begin
      check_dut("d16", 16, a_out_valid, a_in_ready, 32'(a_count), a_opcode, a_op, a_shift,
                a_readnum, a_writenum, 32'(a_sximm5), 32'(a_sximm8), a_illegal, a_nsel_err);
      check_dut("d32", 32, b_out_valid, b_in_ready, 32'(b_count), b_opcode, b_op, b_shift,
                b_readnum, b_writenum, b_sximm5, b_sximm8, b_illegal, b_nsel_err);
   end

   task automatic drive(input logic v, input logic [15:0] w, input logic fl, input logic ordy);
      in_valid  = v;
      in_instr  = w;
      flush     = fl;
      out_ready = ordy;
      @(posedge clk);
      #2;
   endtask

   logic [15:0] burst [4] = '{16'hE000, 16'h5A5A, 16'hC3F7, 16'h2468};

   initial begin
      #12;
      chk("rst.out_valid", a_out_valid, 0);
      chk("rst.in_ready", a_in_ready, 1);
      chk("rst.count", a_count, 0);
      chk("rst.opcode", a_opcode, 0);
      chk("rst.sximm8", b_sximm8, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #2;

      drive(1, 16'hD2A5, 0, 0);
      chk("t1.out_valid", a_out_valid, 1);
      chk("t1.opcode", a_opcode, MOV);
      chk("t1.op", a_op, 2'b10);
      chk("t1.sximm8", a_sximm8, 16'hFFA5);
      chk("t1.sximm5", a_sximm5, 16'h0005);
      chk("t1.sximm8_32", b_sximm8, 32'hFFFF_FFA5);
      chk("t1.readnum_rn", a_readnum, 2);
      nsel = NSEL_RD;
      #1 chk("t1.readnum_rd", a_readnum, 5);
      nsel = NSEL_RM;
      #1 chk("t1.writenum_rm", a_writenum, 5);
      nsel = NSEL_RN;

      drive(1, 16'h6123, 0, 0);
      chk("full.count", a_count, 2);
      chk("full.in_ready", a_in_ready, 0);
      drive(1, 16'h8456, 0, 0);
      chk("stall.count", a_count, 2);
      chk("stall.head", a_opcode, MOV);
      drive(1, 16'h8456, 0, 1);
      chk("popfull.count", a_count, 1);
      chk("popfull.head", a_opcode, LDR);
      drive(1, 16'h8456, 0, 1);
      chk("pushpop.count", a_count, 1);
      chk("pushpop.head", a_opcode, STR);
      drive(1, 16'h1F00, 0, 0);
      drive(1, 16'hA000, 0, 1);
      chk("ill.opcode", a_opcode, 0);
      chk("ill.illegal", a_illegal, 1);
      drive(1, 16'hA000, 0, 1);
      chk("legal.opcode", a_opcode, ALU);
      chk("legal.illegal", a_illegal, 0);

      nsel = 3'b011;
      #1;
      chk("nsel011.readnum", a_readnum, 0);
      chk("nsel011.writenum", a_writenum, 0);
      chk("nsel011.nsel_err", a_nsel_err, 1);

      drive(1, 16'h7777, 0, 0);
      chk("preflush.count", a_count, 2);
      in_valid = 1'b1; in_instr = 16'h1234; flush = 1'b1; out_ready = 1'b1;
      #1 chk("flush.in_ready", a_in_ready, 0);
      @(posedge clk);
      #2;
      chk("flush.count", a_count, 0);
      chk("flush.out_valid", a_out_valid, 0);
      chk("flush.nsel_err", a_nsel_err, 0);
      drive(0, 16'h0000, 0, 0);
      chk("flush.dropped", a_count, 0);
      nsel = NSEL_RN;

      drive(1, 16'h0080, 0, 0);
      chk("imm.sximm8_32", b_sximm8, 32'hFFFF_FF80);
      chk("imm.sximm8_16", a_sximm8, 16'hFF80);
      drive(1, 16'h0010, 0, 1);
      chk("imm.sximm5_32", b_sximm5, 32'hFFFF_FFF0);
      chk("imm.sximm5_16", a_sximm5, 16'hFFF0);

      for (int i = 0; i < 4; i++) begin
         drive(1, burst[i], 0, 1);
         if (i == 0) chk("burst.halt", a_opcode, HALT);
      end
      chk("burst.count", a_count, 1);
      drive(0, 16'h0000, 0, 1);

      drive(1, 16'h3333, 0, 0);
      drive(1, 16'h4444, 0, 0);
      in_valid = 1'b1; in_instr = 16'hBEEF; out_ready = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("arst.out_valid", a_out_valid, 0);
      chk("arst.count", a_count, 0);
      chk("arst.in_ready", a_in_ready, 1);
      chk("arst.opcode", a_opcode, 0);
      chk("arst.sximm8_32", b_sximm8, 0);
      chk("arst.readnum", a_readnum, 0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      drive(0, 16'h0000, 0, 0);
      chk("arst.lost", a_count, 0);
      drive(1, 16'hD2A5, 0, 0);
      chk("recover.opcode", a_opcode, MOV);
      chk("recover.count", a_count, 1);
      drive(0, 16'h0000, 0, 1);
      drive(0, 16'h0000, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
